// File: rtl/clock_display_scan_if.sv
// Digit inputs and display outputs of the clock display scanner.
// The time source drives the digits; the scanner drives the display pins.
interface clock_display_scan_if;
  logic [3:0] hour1;
  logic [3:0] hour0;
  logic [3:0] min1;
  logic [3:0] min0;
  logic [3:0] sec1;
  logic [3:0] sec0;
  logic       lz_en;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output hour1, hour0, min1, min0, sec1, sec0, lz_en,
    input  an, seg, dp
  );

  modport slave (
    input  hour1, hour0, min1, min0, sec1, sec0, lz_en,
    output an, seg, dp
  );
endinterface

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment driver for an hh:mm:ss BCD clock.
// Digits are latched once per frame so a frame never mixes two time values.
module clock_display_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  clock_display_scan_if.slave  dsp
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [3:0]    shadow [6];
  logic          tick;
  logic          frame_end;

  logic [3:0]    cur_digit;
  logic          blank;
  logic [5:0]    next_an;
  logic [6:0]    next_seg;
  logic          next_dp;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign tick      = (cnt == CW'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == 3'd5);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow slot order matches idx: 0=sec0 ... 5=hour1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 6; i++) shadow[i] <= 4'd0;
    end else if (frame_end) begin
      shadow[0] <= dsp.sec0;
      shadow[1] <= dsp.sec1;
      shadow[2] <= dsp.min0;
      shadow[3] <= dsp.min1;
      shadow[4] <= dsp.hour0;
      shadow[5] <= dsp.hour1;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    case (idx)
      3'd0:    cur_digit = shadow[0];
      3'd1:    cur_digit = shadow[1];
      3'd2:    cur_digit = shadow[2];
      3'd3:    cur_digit = shadow[3];
      3'd4:    cur_digit = shadow[4];
      3'd5:    cur_digit = shadow[5];
      default: cur_digit = 4'd0;
    endcase
  end

  // lz_en is used live while the digit it qualifies comes from the shadow.
  always_comb begin
    next_an  = 6'b111111;
    next_seg = 7'b1111111;
    next_dp  = 1'b1;
    blank    = (int'(cnt) < BLANK_CYC) ||
               ((idx == 3'd5) && dsp.lz_en && (cur_digit == 4'd0));
    if (!blank) begin
      next_an  = ~(6'b000001 << idx);
      next_seg = decode(cur_digit);
      next_dp  = !(((idx == 3'd2) || (idx == 3'd4)) && !shadow[0][0]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dsp.an  <= 6'b111111;
      dsp.seg <= 7'b1111111;
      dsp.dp  <= 1'b1;
    end else begin
      dsp.an  <= next_an;
      dsp.seg <= next_seg;
      dsp.dp  <= next_dp;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV=8, BLANK_CYC=2.
// Cycle c means the period after the c-th rising edge since reset release.
module tb_clock_display_scan;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_checks;
  int   n_pass;

  clock_display_scan_if dif ();

  clock_display_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .dsp  (dif)
  );

  typedef struct {
    int          cyc;
    bit          set_in;
    logic [23:0] digits;
    logic        lz;
    bit          chk;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: timeout reached, actual cycle=%0d required=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic add_in(input int c, input logic [23:0] d, input logic lz);
    vec_t v;
    v = '{cyc: c, set_in: 1'b1, digits: d, lz: lz, chk: 1'b0,
          an: 6'h3f, seg: 7'h7f, dp: 1'b1, name: "stim"};
    vecs.push_back(v);
  endtask

  task automatic add_chk(input int c, input logic [5:0] a, input logic [6:0] s,
                         input logic d, input string n);
    vec_t v;
    v = '{cyc: c, set_in: 1'b0, digits: 24'h0, lz: 1'b0, chk: 1'b1,
          an: a, seg: s, dp: d, name: n};
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input logic [23:0] d, input logic lz);
    {dif.hour1, dif.hour0, dif.min1, dif.min0, dif.sec1, dif.sec0} = d;
    dif.lz_en = lz;
  endtask

  task automatic check_output(input string n, input logic [5:0] a,
                              input logic [6:0] s, input logic d);
    n_checks++;
    if ({dif.an, dif.seg, dif.dp} !== {a, s, d})
      $display("[TB] FAIL %s @cycle %0d: actual an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
               n, cyc, dif.an, dif.seg, dif.dp, a, s, d);
    else
      n_pass++;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int blanks;
    logic [5:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    n_checks = 0;
    n_pass   = 0;

    // Frame 1 shows zeros although 12:34:56 is driven from the start.
    add_in (0,  24'h123456, 1'b0);
    add_chk(0,  6'b111111, 7'b1111111, 1'b1, "reset_state");
    add_chk(2,  6'b111111, 7'b1111111, 1'b1, "slot0_blank");
    add_chk(3,  6'b111110, 7'b1000000, 1'b1, "slot0_first_active");
    add_chk(10, 6'b111111, 7'b1111111, 1'b1, "slot1_blank");
    add_chk(11, 6'b111101, 7'b1000000, 1'b1, "slot1_active");
    add_chk(19, 6'b111011, 7'b1000000, 1'b0, "slot2_dp_on");
    add_chk(24, 6'b111011, 7'b1000000, 1'b0, "slot2_last");
    add_chk(25, 6'b111111, 7'b1111111, 1'b1, "slot3_blank");
    add_chk(27, 6'b110111, 7'b1000000, 1'b1, "slot3_active");
    add_chk(35, 6'b101111, 7'b1000000, 1'b0, "slot4_dp_on");
    add_chk(43, 6'b011111, 7'b1000000, 1'b1, "slot5_old_zero");
    add_chk(48, 6'b011111, 7'b1000000, 1'b1, "slot5_last_old");
    add_chk(49, 6'b111111, 7'b1111111, 1'b1, "frame2_blank");
    // Frame 2 shows 12:34:56; inputs change mid-frame at cycle 60.
    add_chk(51, 6'b111110, 7'b0000010, 1'b1, "f2_sec0_6");
    add_chk(59, 6'b111101, 7'b0010010, 1'b1, "f2_sec1_5");
    add_in (60, 24'h09584C, 1'b0);
    add_chk(67, 6'b111011, 7'b0011001, 1'b0, "f2_min0_4_hold");
    add_chk(75, 6'b110111, 7'b0110000, 1'b1, "f2_min1_3_hold");
    add_chk(83, 6'b101111, 7'b0100100, 1'b0, "f2_hour0_2_hold");
    add_chk(91, 6'b011111, 7'b1111001, 1'b1, "f2_hour1_1_hold");
    // Frame 3: 09:58:4C with leading-zero suppression enabled.
    add_chk(99,  6'b111110, 7'b0111111, 1'b1, "f3_sec0_dash");
    add_in (100, 24'h09584C, 1'b1);
    add_chk(107, 6'b111101, 7'b0011001, 1'b1, "f3_sec1_4");
    add_chk(115, 6'b111011, 7'b0000000, 1'b0, "f3_min0_8_dp");
    add_chk(123, 6'b110111, 7'b0010010, 1'b1, "f3_min1_5");
    add_chk(131, 6'b101111, 7'b0010000, 1'b0, "f3_hour0_9_dp");
    add_chk(139, 6'b111111, 7'b1111111, 1'b1, "f3_lz_blank_a");
    add_chk(141, 6'b111111, 7'b1111111, 1'b1, "f3_lz_blank_b");
    add_in (141, 24'h095845, 1'b0);
    add_chk(142, 6'b011111, 7'b1000000, 1'b1, "f3_lz_off_live");
    add_chk(144, 6'b011111, 7'b1000000, 1'b1, "f3_lz_off_last");
    add_chk(145, 6'b111111, 7'b1111111, 1'b1, "f4_blank");
    // Frame 4: odd seconds keep the colon dot off.
    add_chk(147, 6'b111110, 7'b0010010, 1'b1, "f4_sec0_5");
    add_chk(163, 6'b111011, 7'b0000000, 1'b1, "f4_min0_dp_off");
    add_chk(179, 6'b101111, 7'b0010000, 1'b1, "f4_hour0_dp_off");
    add_chk(187, 6'b011111, 7'b1000000, 1'b1, "f4_hour1_0_shown");

    rstn = 1'b0;
    apply_stimulus(24'h000000, 1'b0);
    repeat (2) @(negedge clk);
    check_output("in_reset", 6'b111111, 7'b1111111, 1'b1);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      goto_cycle(vecs[i].cyc);
      if (vecs[i].chk)    check_output(vecs[i].name, vecs[i].an, vecs[i].seg, vecs[i].dp);
      if (vecs[i].set_in) apply_stimulus(vecs[i].digits, vecs[i].lz);
    end

    // Asynchronous reset in the middle of slot 3 of frame 5.
    goto_cycle(219);
    check_output("pre_async_slot3", 6'b110111, 7'b0010010, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_output("async_reset_now", 6'b111111, 7'b1111111, 1'b1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Full frame after reset: scan order, blank slots, cleared shadow.
    blanks = 0;
    for (int c = 1; c <= 48; c++) begin
      goto_cycle(c);
      if (((c - 1) % 8) < 2) begin
        exp_an  = 6'b111111;
        exp_seg = 7'b1111111;
        exp_dp  = 1'b1;
      end else begin
        exp_an  = ~(6'b000001 << ((c - 1) / 8));
        exp_seg = 7'b1000000;
        exp_dp  = !((((c - 1) / 8) == 2) || (((c - 1) / 8) == 4));
      end
      check_output($sformatf("scan_c%0d", c), exp_an, exp_seg, exp_dp);
      if (dif.an == 6'b111111) blanks++;
    end
    n_checks++;
    if (blanks != 12)
      $display("[TB] FAIL blank_count: actual %0d required 12", blanks);
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
